btn_debounce: RTL and testbench

- Input-side counterpart of the display driver: conditions the raw on-board push-buttons into clean, glitch-free control signals for the rest of the design.
- Per button, it synchronises the raw input, debounces it against a shared millisecond timebase, and emits a stable level plus single-cycle press and release pulses.
- Sits between the BTN pads and the counter/reset/hold logic; runs on the internal 0.5 MHz clock.

---
 rtl/btn_debounce.sv | 234 +++++++++++++++++++++++
 tb/tb_btn_debounce.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: per-button synchroniser, debounce FSM and press/release pulse
// generator sharing one millisecond-style tick prescaler.
// Optional auto-repeat of press pulses while a button is held is enabled by
// defining BTN_AUTOREPEAT_EN. The release pulse port is named release_p
// because "release" is a reserved word in SystemVerilog.
module btn_debounce #(
  parameter int NBTN         = 2,
  parameter int TICK_DIV     = 500,
  parameter int DB_TICKS     = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_n,
  output logic [NBTN-1:0] level,
  output logic [NBTN-1:0] press,
  output logic [NBTN-1:0] release_p,
  output logic            tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DB_TICKS + 1);

  // Elaboration-time parameter legality checks
  if (NBTN < 1)         $error("btn_debounce: NBTN must be >= 1");
  if (TICK_DIV < 2)     $error("btn_debounce: TICK_DIV must be >= 2");
  if (DB_TICKS < 1)     $error("btn_debounce: DB_TICKS must be >= 1");
  if (REPEAT_DELAY < 1) $error("btn_debounce: REPEAT_DELAY must be >= 1");
  if (REPEAT_RATE < 1)  $error("btn_debounce: REPEAT_RATE must be >= 1");

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_CONFIRM_P = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_CONFIRM_R = 2'd3
  } state_t;

  logic [NBTN-1:0] sync1_r;
  logic [NBTN-1:0] sync2_r;
  logic [NBTN-1:0] sp_s;
  logic [PW-1:0]   presc_r;
  logic            tick_r;

  state_t          state_r [NBTN];
  state_t          state_s [NBTN];
  logic [CW-1:0]   cnt_r   [NBTN];
  logic [CW-1:0]   cnt_s   [NBTN];

  logic [NBTN-1:0] level_s;
  logic [NBTN-1:0] press_s;
  logic [NBTN-1:0] release_s;
  logic [NBTN-1:0] rep_pulse_s;
  logic [NBTN-1:0] level_r;
  logic [NBTN-1:0] press_r;
  logic [NBTN-1:0] release_r;

  // Two-FF synchroniser; resets to the released (high) pad level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= '1;
      sync2_r <= '1;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
    end
  end

  assign sp_s = ~sync2_r;

  // Prescaler 0..TICK_DIV-1 with a registered one-cycle tick after the wrap value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      tick_r <= (presc_r == PW'(TICK_DIV - 1));
      if (presc_r == PW'(TICK_DIV - 1)) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Debounce next-state logic; a bounce (sp disagreeing) wins over a tick
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      state_s[i]   = state_r[i];
      cnt_s[i]     = cnt_r[i];
      press_s[i]   = 1'b0;
      release_s[i] = 1'b0;
      case (state_r[i])
        ST_RELEASED: begin
          if (sp_s[i]) begin
            state_s[i] = ST_CONFIRM_P;
            cnt_s[i]   = '0;
          end else begin
            state_s[i] = ST_RELEASED;
          end
        end
        ST_CONFIRM_P: begin
          if (!sp_s[i]) begin
            state_s[i] = ST_RELEASED;
          end else if (tick_r) begin
            if (cnt_r[i] == CW'(DB_TICKS - 1)) begin
              state_s[i] = ST_PRESSED;
              cnt_s[i]   = '0;
              press_s[i] = 1'b1;
            end else begin
              cnt_s[i] = cnt_r[i] + CW'(1);
            end
          end else begin
            cnt_s[i] = cnt_r[i];
          end
        end
        ST_PRESSED: begin
          if (!sp_s[i]) begin
            state_s[i] = ST_CONFIRM_R;
            cnt_s[i]   = '0;
          end else begin
            state_s[i] = ST_PRESSED;
          end
        end
        ST_CONFIRM_R: begin
          if (sp_s[i]) begin
            state_s[i] = ST_PRESSED;
          end else if (tick_r) begin
            if (cnt_r[i] == CW'(DB_TICKS - 1)) begin
              state_s[i]   = ST_RELEASED;
              cnt_s[i]     = '0;
              release_s[i] = 1'b1;
            end else begin
              cnt_s[i] = cnt_r[i] + CW'(1);
            end
          end else begin
            cnt_s[i] = cnt_r[i];
          end
        end
        default: begin
          state_s[i] = ST_RELEASED;
          cnt_s[i]   = '0;
        end
      endcase
      level_s[i] = (state_s[i] == ST_PRESSED) || (state_s[i] == ST_CONFIRM_R);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0]   rep_cnt_r [NBTN];
  logic [RW-1:0]   rep_cnt_s [NBTN];
  logic [NBTN-1:0] rep_first_r;
  logic [NBTN-1:0] rep_first_s;

  // Auto-repeat timing: initial delay, then fixed rate; pulses only while staying PRESSED
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      rep_cnt_s[i]   = rep_cnt_r[i];
      rep_first_s[i] = rep_first_r[i];
      rep_pulse_s[i] = 1'b0;
      if ((state_r[i] == ST_CONFIRM_P) && (state_s[i] == ST_PRESSED)) begin
        rep_cnt_s[i]   = '0;
        rep_first_s[i] = 1'b0;
      end else if (((state_r[i] == ST_PRESSED) || (state_r[i] == ST_CONFIRM_R)) && tick_r) begin
        if (!rep_first_r[i]) begin
          if (rep_cnt_r[i] == RW'(REPEAT_DELAY - 1)) begin
            rep_cnt_s[i]   = '0;
            rep_first_s[i] = 1'b1;
            rep_pulse_s[i] = (state_s[i] == ST_PRESSED);
          end else begin
            rep_cnt_s[i] = rep_cnt_r[i] + RW'(1);
          end
        end else begin
          if (rep_cnt_r[i] == RW'(REPEAT_RATE - 1)) begin
            rep_cnt_s[i]   = '0;
            rep_pulse_s[i] = (state_s[i] == ST_PRESSED);
          end else begin
            rep_cnt_s[i] = rep_cnt_r[i] + RW'(1);
          end
        end
      end else begin
        rep_cnt_s[i] = rep_cnt_r[i];
      end
    end
  end

  // Auto-repeat counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBTN; i++) begin
        rep_cnt_r[i] <= '0;
      end
      rep_first_r <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        rep_cnt_r[i] <= rep_cnt_s[i];
      end
      rep_first_r <= rep_first_s;
    end
  end
`else
  assign rep_pulse_s = '0;
`endif

  // FSM state, confirm counters and registered level/pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBTN; i++) begin
        state_r[i] <= ST_RELEASED;
        cnt_r[i]   <= '0;
      end
      level_r   <= '0;
      press_r   <= '0;
      release_r <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
      level_r   <= level_s;
      press_r   <= press_s | rep_pulse_s;
      release_r <= release_s;
    end
  end

  assign level     = level_r;
  assign press     = press_r;
  assign release_p = release_r;
  assign tick      = tick_r;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed testbench for btn_debounce (TICK_DIV=4, DB_TICKS=3, NBTN=2,
// REPEAT_DELAY=5, REPEAT_RATE=2). Define BTN_AUTOREPEAT_EN for both files to
// exercise the auto-repeat build.
module tb_btn_debounce;

  localparam int NB = 2;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RR = 2;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] level;
  logic [NB-1:0] press;
  logic [NB-1:0] release_p;
  logic          tick;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] btn_n;
    int         ncyc;
    logic [1:0] exp_level;
    logic [1:0] exp_press;
    logic [1:0] exp_rel;
  } vec_t;

  vec_t vecs [8];

  btn_debounce #(
    .NBTN(NB), .TICK_DIV(TD), .DB_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .level(level),
    .press(press), .release_p(release_p), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive drv, then expect the pulse one sample after the 3rd tick that the
  // confirm state can consume (state enters CONFIRM three edges after drive).
  task automatic accept(input logic [1:0] drv, input bit is_press,
                        input logic [1:0] exp_level, input logic [1:0] exp_pulse,
                        input string nm);
    int  ntk;
    bit  done;
    ntk   = 0;
    done  = 1'b0;
    btn_n = drv;
    for (int j = 1; j <= 60 && !done; j++) begin
      cyc();
      if (j >= 3 && tick) ntk++;
      if (ntk == DB) begin
        chk({nm, "_pre"}, is_press ? press : release_p, 2'b00);
        cyc();
        chk({nm, "_press"}, press, is_press ? exp_pulse : 2'b00);
        chk({nm, "_release"}, release_p, is_press ? 2'b00 : exp_pulse);
        chk({nm, "_level"}, level, exp_level);
        cyc();
        chk({nm, "_pulse_off"}, {press, release_p}, 4'b0000);
        done = 1'b1;
      end
    end
    if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int  pc [2];
    int  rc [2];
    int  ovl;
    int  bad;
    int  nt;
    bit  both;
    bit  first;
    bit  pend;
    bit  exp_p;

    vecs[0] = '{2'b11, 40, 2'b00, 2'b00, 2'b01};
    vecs[1] = '{2'b00, 40, 2'b11, 2'b11, 2'b00};
    vecs[2] = '{2'b10, 40, 2'b01, 2'b00, 2'b10};
    vecs[3] = '{2'b11, 40, 2'b00, 2'b00, 2'b01};
    vecs[4] = '{2'b01,  2, 2'b00, 2'b00, 2'b00};
    vecs[5] = '{2'b11, 30, 2'b00, 2'b00, 2'b00};
    vecs[6] = '{2'b10,  8, 2'b00, 2'b00, 2'b00};
    vecs[7] = '{2'b11, 30, 2'b00, 2'b00, 2'b00};

    // Reset state
    reset = 1'b1;
    btn_n = 2'b11;
    cyc();
    cyc();
    chk("rst_level", level, 2'b00);
    chk("rst_press", press, 2'b00);
    chk("rst_release", release_p, 2'b00);
    chk("rst_tick", tick, 1'b0);
    reset = 1'b0;

    // Idle: no activity, tick every TD clk, one clk wide
    for (int k = 1; k <= 100; k++) begin
      cyc();
      chk($sformatf("idle_tick_%0d", k), tick, (k % TD == 0) ? 1'b1 : 1'b0);
      chk($sformatf("idle_out_%0d", k), {level, press, release_p}, 6'b000000);
    end

    // Clean press and release of bit 0 with exact timing
    accept(2'b10, 1'b1, 2'b01, 2'b01, "press0");
    accept(2'b11, 1'b0, 2'b00, 2'b01, "release0");

    // Bounce on bit 0: toggles every 3 clk for 40 clk, then held
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      btn_n = {1'b1, ((k / 3) % 2 == 0) ? 1'b0 : 1'b1};
      cyc();
      if ({level, press, release_p} != 6'b000000) bad++;
    end
    chk("bounce_quiet", bad, 0);
    btn_n = 2'b10;
    pc[0] = 0;
    rc[0] = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      pc[0] += int'(press[0]);
      rc[0] += int'(release_p[0]);
    end
    chk("bounce_press_cnt", pc[0], 1);
    chk("bounce_rel_cnt", rc[0], 0);
    chk("bounce_level", level, 2'b01);

    // Table-driven vectors (first entry releases bit 0)
    for (int v = 0; v < 8; v++) begin
      pc    = '{0, 0};
      rc    = '{0, 0};
      ovl   = 0;
      both  = 1'b0;
      btn_n = vecs[v].btn_n;
      for (int c = 0; c < vecs[v].ncyc; c++) begin
        cyc();
        for (int b = 0; b < NB; b++) begin
          pc[b] += int'(press[b]);
          rc[b] += int'(release_p[b]);
        end
        if ((press & release_p) != 2'b00) ovl++;
        if (press == 2'b11) both = 1'b1;
      end
      chk($sformatf("vec%0d_level", v), level, vecs[v].exp_level);
      for (int b = 0; b < NB; b++) begin
        chk($sformatf("vec%0d_press%0d", v, b), pc[b], int'(vecs[v].exp_press[b]));
        chk($sformatf("vec%0d_rel%0d", v, b), rc[b], int'(vecs[v].exp_rel[b]));
      end
      chk($sformatf("vec%0d_overlap", v), ovl, 0);
      if (v == 1) chk("vec1_same_clk_press", both, 1'b1);
    end

    // Reset while bit 0 is accepted and still held
    btn_n = 2'b10;
    for (int k = 0; k < 40; k++) cyc();
    chk("pre_reset_level", level, 2'b01);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_out", {level, press, release_p, tick}, 7'd0);
    cyc();
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk($sformatf("rearm_press_%0d", k), press, (k == 13) ? 2'b01 : 2'b00);
      chk($sformatf("rearm_level_%0d", k), level, (k >= 13) ? 2'b01 : 2'b00);
      chk($sformatf("rearm_rel_%0d", k), release_p, 2'b00);
    end

    // Long hold: auto-repeat schedule when enabled, single press otherwise
    accept(2'b11, 1'b0, 2'b00, 2'b01, "release_b");
    accept(2'b10, 1'b1, 2'b01, 2'b01, "press_hold");
    nt    = 0;
    first = 1'b0;
    pend  = 1'b0;
    for (int k = 0; k < 30 * TD; k++) begin
      cyc();
      exp_p = pend;
      pend  = 1'b0;
      chk($sformatf("hold_press_%0d", k), press, {1'b0, exp_p});
      chk($sformatf("hold_level_%0d", k), level, 2'b01);
      if (tick) begin
        nt++;
        if (!first && nt == RD) begin
          pend  = REP_EN;
          nt    = 0;
          first = 1'b1;
        end else if (first && nt == RR) begin
          pend = REP_EN;
          nt   = 0;
        end
      end
    end
    accept(2'b11, 1'b0, 2'b00, 2'b01, "release_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
